alu_exec_unit: RTL and testbench

- Execute-stage ALU: the consumer of the 4-bit Operation code produced by the ALU controller.
- Takes two operands plus an operation code over a valid/ready handshake and returns a registered result, a branch-condition flag and an illegal-op flag.
- Single-cycle ops complete in 1 cycle. Shifts run iteratively, 1 bit per cycle.
- Sits between the ID/EX pipeline register and the EX/MEM register; `in_ready` low stalls the front of the pipeline.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/alu_shift_iter.sv | 64 ++++++
 rtl/alu_exec_unit.sv | 157 +++++++++++++++
 tb/tb_alu_exec_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the execute-stage ALU.
//   alu_op_e      : 4-bit operation code, shared with the ALU controller.
//   alu_state_e   : control FSM states of alu_exec_unit.
//   shift_mode_e  : direction / fill control for the shifters.
//   is_compare()  : op produces a branch condition (EQ, NE, LT, GE).
//   is_shift()    : op is SLL, SRL or SRA.
//   shift_mode()  : maps a shift op code onto a shift_mode_e.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_XOR = 4'b0010,
    OP_ADD = 4'b0011,
    OP_SLL = 4'b0100,
    OP_EQ  = 4'b0101,
    OP_NE  = 4'b0110,
    OP_LT  = 4'b0111,
    OP_SRL = 4'b1000,
    OP_SRA = 4'b1001,
    OP_SUB = 4'b1010,
    OP_GE  = 4'b1011,
    OP_LUI = 4'b1100
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_mode_e;

  function automatic logic is_compare(input logic [3:0] op);
    return (op == OP_EQ) || (op == OP_NE) || (op == OP_LT) || (op == OP_GE);
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic shift_mode_e shift_mode(input logic [3:0] op);
    shift_mode_e m;
    case (op)
      OP_SRL:  m = SH_RL;
      OP_SRA:  m = SH_RA;
      default: m = SH_LL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter -- iterative 1-bit-per-cycle shifter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load din/shamt/mode (shamt must be nonzero)
//   mode       : SH_LL / SH_RL / SH_RA
//   din        : value to shift
//   shamt      : number of bit positions
//   busy       : shift in progress
//   done       : this cycle performs the final shift; dout is the final value
//   dout       : working register shifted by one more position
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  shift_mode_e                   mode,
  input  logic [DATA_WIDTH-1:0]         din,
  input  logic [$clog2(DATA_WIDTH)-1:0] shamt,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_WIDTH-1:0]         dout
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] work_reg;
  logic [DATA_WIDTH-1:0] work_next;
  logic [SHAMT_W-1:0]    count_reg;
  shift_mode_e           mode_reg;

  always_comb begin
    work_next = work_reg << 1;
    case (mode_reg)
      SH_RL:   work_next = {1'b0, work_reg[DATA_WIDTH-1:1]};
      SH_RA:   work_next = {work_reg[DATA_WIDTH-1], work_reg[DATA_WIDTH-1:1]};
      default: work_next = {work_reg[DATA_WIDTH-2:0], 1'b0};
    endcase
  end

  // count_reg holds the shifts still to perform; the last one (count==1)
  // is presented on dout so the caller captures it on the same edge.
  assign busy = (count_reg != '0);
  assign done = (count_reg == SHAMT_W'(1));
  assign dout = work_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg  <= '0;
      count_reg <= '0;
      mode_reg  <= SH_LL;
    end else if (start) begin
      work_reg  <= din;
      count_reg <= shamt;
      mode_reg  <= mode;
    end else if (count_reg != '0) begin
      work_reg  <= work_next;
      count_reg <= count_reg - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage ALU with valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (operation, src_a, src_b)
//   out_valid/out_ready : result handshake (result, branch_taken, op_illegal)
// Single-cycle ops load the result on the accept edge. Shifts run one bit
// per cycle in alu_shift_iter, unless ALU_FAST_SHIFT_EN is defined, in which
// case a combinational barrel shifter gives them single-cycle latency too.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_taken,
  output logic                  op_illegal
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  branch_reg;
  logic                  illegal_reg;
  logic                  accept;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] alu_val;
  logic                  cmp_cond;
  logic                  alu_ill;
  logic [DATA_WIDTH-1:0] shift_val;

  assign shamt = src_b[SHAMT_W-1:0];

`ifdef ALU_FAST_SHIFT_EN
  // Log-depth barrel shifter: stage gi shifts by 2**gi when shamt[gi] is set.
  logic [SHAMT_W:0][DATA_WIDTH-1:0] stage_val;
  logic                             fill_bit;

  assign fill_bit     = (operation == OP_SRA) && src_a[DATA_WIDTH-1];
  assign stage_val[0] = src_a;

  for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_barrel
    localparam int STEP = 2 ** gi;
    logic [DATA_WIDTH-1:0] left_val;
    logic [DATA_WIDTH-1:0] right_val;
    assign left_val  = {stage_val[gi][DATA_WIDTH-1-STEP:0], {STEP{1'b0}}};
    assign right_val = {{STEP{fill_bit}}, stage_val[gi][DATA_WIDTH-1:STEP]};
    assign stage_val[gi+1] = !shamt[gi] ? stage_val[gi] :
                             (operation == OP_SLL) ? left_val : right_val;
  end

  assign shift_val = stage_val[SHAMT_W];
  assign in_ready  = !out_valid_reg || out_ready;
`else
  alu_state_e            state_reg;
  logic                  shift_start;
  logic                  shift_busy;
  logic                  shift_done;
  logic [DATA_WIDTH-1:0] shift_dout;

  // shamt==0 needs no iteration: the result is src_a, loaded like any
  // single-cycle op, so only nonzero shifts start the iterative shifter.
  assign shift_val   = src_a;
  assign shift_start = accept && is_shift(operation) && (shamt != '0);
  assign in_ready    = (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);

  alu_shift_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (shift_start),
    .mode  (shift_mode(operation)),
    .din   (src_a),
    .shamt (shamt),
    .busy  (shift_busy),
    .done  (shift_done),
    .dout  (shift_dout)
  );
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    alu_val  = '0;
    cmp_cond = 1'b0;
    alu_ill  = 1'b0;
    case (operation)
      OP_AND:  alu_val = src_a & src_b;
      OP_OR:   alu_val = src_a | src_b;
      OP_XOR:  alu_val = src_a ^ src_b;
      OP_ADD:  alu_val = src_a + src_b;
      OP_SUB:  alu_val = src_a - src_b;
      OP_LUI:  alu_val = src_b;
      OP_SLL, OP_SRL, OP_SRA: alu_val = shift_val;
      OP_EQ:   cmp_cond = (src_a == src_b);
      OP_NE:   cmp_cond = (src_a != src_b);
      OP_LT:   cmp_cond = ($signed(src_a) < $signed(src_b));
      OP_GE:   cmp_cond = ($signed(src_a) >= $signed(src_b));
      default: alu_ill = 1'b1;
    endcase
    if (is_compare(operation)) begin
      alu_val = {{(DATA_WIDTH-1){1'b0}}, cmp_cond};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      branch_reg    <= 1'b0;
      illegal_reg   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      state_reg     <= ST_IDLE;
`endif
    end else begin
`ifndef ALU_FAST_SHIFT_EN
      if (shift_start) begin
        // in_ready guaranteed any previous result is consumed on this edge.
        out_valid_reg <= 1'b0;
        state_reg     <= ST_SHIFT;
      end else if (state_reg == ST_SHIFT) begin
        if (shift_busy && shift_done) begin
          result_reg    <= shift_dout;
          branch_reg    <= 1'b0;
          illegal_reg   <= 1'b0;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_IDLE;
        end
      end else
`endif
      if (accept) begin
        result_reg    <= alu_val;
        branch_reg    <= cmp_cond;
        illegal_reg   <= alu_ill;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign result       = result_reg;
  assign branch_taken = branch_reg;
  assign op_illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit -- directed vectors with a scoreboard queue. The driver
// pushes the hand-computed response when a request is accepted; a monitor
// pops and compares whenever a result is handed over. Build with
// ALU_FAST_SHIFT_EN defined to exercise the barrel-shifter variant.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  operation = 4'h0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        branch_taken;
  logic        op_illegal;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] res;
    logic        br;
    logic        ill;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  bit   head_seen = 1'b0;

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operation    (operation),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .branch_taken (branch_taken),
    .op_illegal   (op_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int slat(input int s);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return s + 1;
`endif
  endfunction

  // Monitor: latency is measured when a result first appears, values are
  // compared when it is handed over (out_ready high through the next edge).
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got result=%h expected no output", result);
      end else begin
        if (!head_seen) begin
          chk({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
          head_seen = 1'b1;
        end
        if (out_ready) begin
          chk({sb[0].name, "_result"}, result, sb[0].res);
          chk({sb[0].name, "_branch"}, 32'(branch_taken), 32'(sb[0].br));
          chk({sb[0].name, "_illegal"}, 32'(op_illegal), 32'(sb[0].ill));
          $display("txn %s result=%h branch=%b illegal=%b", sb[0].name, result,
                   branch_taken, op_illegal);
          void'(sb.pop_front());
          head_seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic br,
                       input logic ill, input int lat, input bit push);
    exp_t e;
    int   n = 0;
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL %s_accept_timeout: got in_ready=0 expected 1 within 200 cycles", name);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (push) begin
      e.res = res; e.br = br; e.ill = ill; e.lat = lat; e.acc = cyc; e.name = name;
      sb.push_back(e);
    end
    // Scramble inputs: the unit must only use values captured at accept.
    in_valid  = 1'b0;
    src_a     = 32'hDEAD_BEEF;
    src_b     = 32'hFFFF_FFFF;
    operation = 4'hF;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    int seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'h0);
    chk("reset_branch", 32'(branch_taken), 32'd0);
    chk("reset_illegal", 32'(op_illegal), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    issue("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, 0, 1, 1);
    issue("lt_neg", OP_LT, 32'hFFFF_FFFE, 32'h1, 32'h1, 1, 0, 1, 1);
    issue("ge_neg", OP_GE, 32'hFFFF_FFFE, 32'h1, 32'h0, 0, 0, 1, 1);
    issue("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 0, 0, 1, 1);
    issue("or", OP_OR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 0, 0, 1, 1);
    issue("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 0, 0, 1, 1);
    issue("sub", OP_SUB, 32'h3, 32'h5, 32'hFFFF_FFFE, 0, 0, 1, 1);
    issue("eq_ne", OP_EQ, 32'h5, 32'h4, 32'h0, 0, 0, 1, 1);
    issue("ne", OP_NE, 32'h5, 32'h4, 32'h1, 1, 0, 1, 1);
    issue("lui", OP_LUI, 32'h1234, 32'hABCD_E000, 32'hABCD_E000, 0, 0, 1, 1);
    issue("lt_min", OP_LT, 32'h7, 32'h8000_0000, 32'h0, 0, 0, 1, 1);
    issue("ge_min", OP_GE, 32'h8000_0000, 32'h7, 32'h0, 0, 0, 1, 1);
    issue("ge_eq", OP_GE, 32'h7, 32'h7, 32'h1, 1, 0, 1, 1);

    issue("sll8", OP_SLL, 32'h0000_00F1, 32'h8, 32'h0000_F100, 0, 0, slat(8), 1);
    issue("srl4", OP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000, 0, 0, slat(4), 1);
    issue("sra4", OP_SRA, 32'h8000_0000, 32'h24, 32'hF800_0000, 0, 0, slat(4), 1);
`ifndef ALU_FAST_SHIFT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sra4_busy_in_ready", 32'(in_ready), 32'd0);
    end
`endif
    issue("sra0", OP_SRA, 32'h8000_0001, 32'h20, 32'h8000_0001, 0, 0, slat(0), 1);
    issue("srl31", OP_SRL, 32'hFFFF_FFFF, 32'h1F, 32'h0000_0001, 0, 0, slat(31), 1);
    issue("sra1", OP_SRA, 32'h7FFF_FFFF, 32'h1, 32'h3FFF_FFFF, 0, 0, slat(1), 1);

    issue("illegal_f", 4'hF, 32'h1234, 32'h5678, 32'h0, 0, 1, 1, 1);
    issue("illegal_d", 4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 1, 1, 1);
    issue("eq_same", OP_EQ, 32'h5, 32'h5, 32'h1, 1, 0, 1, 1);

    // Backpressure: pending result held for 3 cycles with a new request waiting.
    drain();
    out_ready = 1'b0;
    issue("bp_add", OP_ADD, 32'h1, 32'h2, 32'h3, 0, 0, 1, 1);
    operation = OP_XOR;
    src_a     = 32'h0000_F0F0;
    src_b     = 32'h0000_FF00;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result_stable", result, 32'h3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    c0 = cyc;
    issue("bp_xor", OP_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0, 0, 1, 1);
    chk("bp_same_edge_accept", 32'(cyc), 32'(c0 + 1));

    // Back-to-back single-cycle ops: one accept per cycle.
    c0 = cyc;
    issue("b2b_add", OP_ADD, 32'd10, 32'd20, 32'h0000_001E, 0, 0, 1, 1);
    issue("b2b_sub", OP_SUB, 32'd10, 32'd20, 32'hFFFF_FFF6, 0, 0, 1, 1);
    issue("b2b_or", OP_OR, 32'h0F, 32'hF0, 32'h0000_00FF, 0, 0, 1, 1);
    chk("b2b_rate", 32'(cyc), 32'(c0 + 3));

    // Reset during a long shift: nothing may be emitted afterwards.
    drain();
`ifdef ALU_FAST_SHIFT_EN
    issue("sll31", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 0, 0, 1, 1);
`else
    issue("sll31", OP_SLL, 32'h1, 32'd31, 32'h8000_0000, 0, 0, slat(31), 0);
`endif
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_result", 32'(seen), 32'd0);

    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
